// File: rtl/uart_tx_unit.sv
// UART transmitter: holding register, single-depth send request and 8N1 framer.
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_unit #(
    parameter int unsigned BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_data_en,
    input  logic [7:0] Tx_Data_w,
    input  logic       tx_send_en,
    input  logic       tx_send,
    output logic       tx,
    output logic       tx_fsm_in_STOP_S,
    output logic       tx_busy
);

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    state_t      state_r;
    logic [15:0] baud_cnt_r;
    logic [2:0]  bit_idx_r;
    logic [7:0]  hold_r;
    logic [7:0]  shift_r;
    logic        send_pend_r;
    logic        tx_r;
    logic        stop_r;
    logic        busy_r;

    logic        baud_last_s;
    logic [2:0]  next_bit_s;

    assign baud_last_s      = (baud_cnt_r == BAUD_LAST);
    assign next_bit_s       = bit_idx_r + 3'd1;

    assign tx               = tx_r;
    assign tx_fsm_in_STOP_S = stop_r;
    assign tx_busy          = busy_r;

    // Holding register: software writes land here in any state; the frame uses shift_r.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_r <= 8'd0;
        end else if (tx_data_en) begin
            hold_r <= Tx_Data_w;
        end else begin
            hold_r <= hold_r;
        end
    end

    // Single-depth send request; a software write wins over the launch-time clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            send_pend_r <= 1'b0;
        end else if (tx_send_en) begin
            send_pend_r <= tx_send;
        end else if ((state_r == IDLE) && send_pend_r) begin
            send_pend_r <= 1'b0;
        end else begin
            send_pend_r <= send_pend_r;
        end
    end

    // Frame sequencer; line, stop flag and busy are registered with the state change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            baud_cnt_r <= 16'd0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            tx_r       <= 1'b1;
            stop_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    baud_cnt_r <= 16'd0;
                    bit_idx_r  <= 3'd0;
                    stop_r     <= 1'b0;
                    if (send_pend_r) begin
                        state_r <= START;
                        shift_r <= hold_r;
                        tx_r    <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        tx_r    <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                START: begin
                    if (baud_last_s) begin
                        baud_cnt_r <= 16'd0;
                        bit_idx_r  <= 3'd0;
                        state_r    <= DATA;
                        tx_r       <= shift_r[0];
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                DATA: begin
                    if (baud_last_s) begin
                        baud_cnt_r <= 16'd0;
                        if (bit_idx_r == 3'd7) begin
                            bit_idx_r <= 3'd0;
`ifdef UART_TX_PARITY_EN
                            state_r   <= PARITY;
                            tx_r      <= even_parity(shift_r);
`else
                            state_r   <= STOP;
                            tx_r      <= 1'b1;
                            stop_r    <= 1'b1;
`endif
                        end else begin
                            bit_idx_r <= next_bit_s;
                            tx_r      <= shift_r[next_bit_s];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_last_s) begin
                        baud_cnt_r <= 16'd0;
                        state_r    <= STOP;
                        tx_r       <= 1'b1;
                        stop_r     <= 1'b1;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
`endif
                STOP: begin
                    if (baud_last_s) begin
                        baud_cnt_r <= 16'd0;
                        state_r    <= IDLE;
                        tx_r       <= 1'b1;
                        stop_r     <= 1'b0;
                        busy_r     <= 1'b0;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    baud_cnt_r <= 16'd0;
                    bit_idx_r  <= 3'd0;
                    tx_r       <= 1'b1;
                    stop_r     <= 1'b0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_unit.sv
// Directed self-checking bench for uart_tx_unit at BAUD_DIV=4 (parity-aware via UART_TX_PARITY_EN).
module tb_uart_tx_unit;

    localparam int BAUD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_data_en = 1'b0;
    logic [7:0] Tx_Data_w = 8'h00;
    logic       tx_send_en = 1'b0;
    logic       tx_send = 1'b0;
    logic       tx;
    logic       tx_fsm_in_STOP_S;
    logic       tx_busy;

    int checks = 0;
    int failures = 0;

    uart_tx_unit #(.BAUD_DIV(BAUD)) dut (
        .clk              (clk),
        .rst              (rst),
        .tx_data_en       (tx_data_en),
        .Tx_Data_w        (Tx_Data_w),
        .tx_send_en       (tx_send_en),
        .tx_send          (tx_send),
        .tx               (tx),
        .tx_fsm_in_STOP_S (tx_fsm_in_STOP_S),
        .tx_busy          (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Expected line level for frame bit k: start, LSB-first data, [even parity], stop.
    function automatic logic exp_bit(input logic [7:0] d, input int k);
        logic b;
        if (k == 0) b = 1'b0;
        else if (k <= 8) b = d[k-1];
`ifdef UART_TX_PARITY_EN
        else if (k == 9) b = ^d;
`endif
        else b = 1'b1;
        return b;
    endfunction

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, tx_busy, 1'b0);
        chk({tag, "_tx"}, tx, 1'b1);
        chk({tag, "_stop"}, tx_fsm_in_STOP_S, 1'b0);
    endtask

    // Load (optional) then send; returns just after the edge that enters START.
    task automatic launch(input logic load, input logic [7:0] d);
        if (load) begin
            tx_data_en = 1'b1;
            Tx_Data_w  = d;
            tick;
            tx_data_en = 1'b0;
        end
        tx_send_en = 1'b1;
        tx_send    = 1'b1;
        tick;
        check_idle("pre_start");
        tx_send_en = 1'b0;
        tick;
    endtask

    // Checks every cycle of one frame from the START edge; can inject writes at given cycles.
    task automatic run_frame(input logic [7:0] d,
                             input int wr_cyc, input logic [7:0] wr_data,
                             input int s1_cyc, input logic s1_val,
                             input int s2_cyc, input logic s2_val);
        for (int c = 0; c < NBITS * BAUD; c++) begin
            chk("frame_tx", tx, exp_bit(d, c / BAUD));
            chk("frame_stop", tx_fsm_in_STOP_S, ((c / BAUD) == (NBITS - 1)) ? 8'd1 : 8'd0);
            chk("frame_busy", tx_busy, 1'b1);
            tx_data_en = (c == wr_cyc);
            Tx_Data_w  = wr_data;
            tx_send_en = (c == s1_cyc) || (c == s2_cyc);
            tx_send    = (c == s2_cyc) ? s2_val : s1_val;
            tick;
            tx_data_en = 1'b0;
            tx_send_en = 1'b0;
        end
        check_idle("frame_end");
    endtask

    initial begin
        // Reset state
        #2 rst = 1'b0;
        #1 check_idle("reset");
        tick;
        tick;
        rst = 1'b1;
        tick;
        check_idle("after_reset");

        // Basic frame 0xA5, then no spontaneous second frame
        launch(1'b1, 8'hA5);
        run_frame(8'hA5, -1, 8'h00, -1, 1'b0, -1, 1'b0);
        tick;
        check_idle("a5_quiet");

        // 0x07: odd popcount, parity bit 1 when enabled
        launch(1'b1, 8'h07);
        run_frame(8'h07, -1, 8'h00, -1, 1'b0, -1, 1'b0);

        // Holding write mid-frame does not disturb 0x5A; next send carries 0x3C
        launch(1'b1, 8'h5A);
        run_frame(8'h5A, 14, 8'h3C, -1, 1'b0, -1, 1'b0);
        tick;
        check_idle("5a_quiet");
        launch(1'b0, 8'h00);
        run_frame(8'h3C, -1, 8'h00, -1, 1'b0, -1, 1'b0);

        // Double send during DATA: one back-to-back frame after exactly one IDLE cycle
        launch(1'b1, 8'h81);
        run_frame(8'h81, -1, 8'h00, 10, 1'b1, 20, 1'b1);
        tick;
        chk("b2b_start_tx", tx, 1'b0);
        chk("b2b_start_busy", tx_busy, 1'b1);
        run_frame(8'h81, -1, 8'h00, -1, 1'b0, -1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick;
            check_idle("b2b_no_third");
        end

        // Send then cancel while busy: current frame completes, nothing follows
        launch(1'b1, 8'hC3);
        run_frame(8'hC3, -1, 8'h00, 8, 1'b1, 16, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("cancel_busy", tx_busy, 1'b0);
        end

        // Asynchronous reset during DATA bit 3 (0x96 bit 3 = 0)
        launch(1'b1, 8'h96);
        for (int i = 0; i < 17; i++) tick;
        chk("bit3_tx", tx, 1'b0);
        chk("bit3_busy", tx_busy, 1'b1);
        #2 rst = 1'b0;
        #1;
        check_idle("async_rst");
        tick;
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick;
            check_idle("post_rst_idle");
        end
        // Holding register was cleared, so a bare send transmits 0x00
        launch(1'b0, 8'h00);
        run_frame(8'h00, -1, 8'h00, -1, 1'b0, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_unit.md
UART_TX_UNIT -- requirements
Module: uart_tx_unit

Interface
REQ-001 The block SHALL declare parameter BAUD_DIV, default 434, meaning clock cycles per serial bit (legal range 2..65535).
REQ-002 The block SHALL declare port clk  input  1  system clock; all state updates on rising edge.
REQ-003 The block SHALL declare port rst  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL declare port tx_data_en  input  1  write strobe that loads the transmit holding register.
REQ-005 The block SHALL declare port Tx_Data_w  input  8  byte to be transmitted.
REQ-006 The block SHALL declare port tx_send_en  input  1  write strobe for the send-control register.
REQ-007 The block SHALL declare port tx_send  input  1  send-control value: 1 requests a frame, 0 cancels a pending request.
REQ-008 The block SHALL declare port tx  output  1  serial line, idle high.
REQ-009 The block SHALL declare port tx_fsm_in_STOP_S  output  1  high while the FSM is in STOP (software done indicator).
REQ-010 The block SHALL declare port tx_busy  output  1  high in any state other than IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; PARITY SHALL exist only per REQ-027.
REQ-012 A tx_data_en=1 cycle SHALL load Tx_Data_w into the holding register at that edge, in any FSM state.
REQ-013 A tx_send_en=1 cycle SHALL set send_pend to tx_send at that edge.
REQ-014 When tx_send_en=1 and the FSM leaves IDLE on the same edge, the tx_send_en write SHALL take priority over the clear in REQ-015.
REQ-015 IDLE with send_pend=1 SHALL transition to START at the next edge; the same edge SHALL clear send_pend and copy the holding register into the shift register.
REQ-016 If tx_data_en coincides with that transition edge, the shift register SHALL receive the old holding value and the holding register the new one.
REQ-017 A baud counter SHALL count 0..BAUD_DIV-1 and reset to 0 on every state or bit change.
REQ-018 Each state except IDLE SHALL hold each bit exactly BAUD_DIV cycles.
REQ-019 START SHALL drive tx=0.
REQ-020 DATA SHALL send 8 bits LSB first using a 3-bit bit index that wraps 7->0 on the exit to PARITY or STOP.
REQ-021 STOP SHALL drive tx=1 and assert tx_fsm_in_STOP_S, then return to IDLE.
REQ-022 Writes to the holding register during a frame SHALL NOT alter the bits in flight.
REQ-023 A send_pend set during a frame SHALL start the next frame after exactly one IDLE cycle.
REQ-024 A tx_send=0 write while send_pend=1 SHALL cancel the request, and SHALL NOT abort a frame already in progress.
REQ-025 A tx_send_en write with tx_send=1 while send_pend=1 SHALL NOT queue a second frame (single-depth request).

Reset
REQ-026 Asserting rst at any time, including mid-frame, SHALL immediately force tx=1, tx_fsm_in_STOP_S=0, tx_busy=0, state IDLE, send_pend=0, holding register=0, shift register=0, and baud counter and bit index=0.

Configuration
REQ-027 With UART_TX_PARITY_EN defined, a PARITY state SHALL follow DATA for BAUD_DIV cycles and drive the even-parity bit (XOR of the 8 data bits); without the macro, DATA SHALL go directly to STOP and the frame SHALL be 10 bits.

Verification
REQ-028 BAUD_DIV=4, no parity; tx_data_en with Tx_Data_w=0xA5, then tx_send_en with tx_send=1 -> tx goes low 2 edges after the send write and carries 0,1,0,1,0,0,1,0,1,1 at 4 cycles per bit; tx_fsm_in_STOP_S is high for exactly 4 cycles.
REQ-029 Same stimulus with UART_TX_PARITY_EN defined -> parity bit 0 is inserted before the stop bit; frame is 44 cycles; 0x07 gives parity 1.
REQ-030 tx_data_en with 0x3C in the middle of frame 0x5A -> the line still carries 0x5A; a following send transmits 0x3C.
REQ-031 Send written during the DATA state -> second frame START begins exactly 1 cycle after the first frame's STOP ends; a double send write yields only one extra frame.
REQ-032 Send with tx_send=1 then tx_send=0 while busy -> only the current frame completes; tx_busy drops and stays 0.
REQ-033 rst asserted during DATA bit 3 -> tx=1 and tx_busy=0 immediately, without waiting for a clock edge; after release, no frame starts until a new send write.
